// File: rtl/lzma2_compression_pkg.sv
// rtl/lzma2_compression_pkg.sv - shared compressor constants and types
package lzma2_compression_pkg;

    localparam int PARALLEL_HASH_UNITS = 8;
    localparam int HASH_BITS           = 15;
    localparam int WINDOW_POS_BITS     = 15;

    typedef struct packed {
        logic                       write;
        logic [HASH_BITS-1:0]       hash;
        logic [WINDOW_POS_BITS-1:0] pos;
    } hash_req_t;

    typedef enum logic [1:0] {
        CLEAR,
        RUN,
        DRAIN
    } arb_state_t;

    typedef struct packed {
        logic        valid;
        logic [14:0] pos;
    } hash_head_t;

endpackage

// File: rtl/lzma2_hash_bank_arbiter_if.sv
// rtl/lzma2_hash_bank_arbiter_if.sv - hash-unit request/response bundle
interface lzma2_hash_bank_arbiter_if #(
    parameter int NUM_REQ   = 8,
    parameter int HASH_BITS = 15,
    parameter int POS_BITS  = 15
);
    logic [NUM_REQ-1:0]           req_valid;
    logic [NUM_REQ-1:0]           req_write;
    logic [NUM_REQ*HASH_BITS-1:0] req_hash;
    logic [NUM_REQ*POS_BITS-1:0]  req_pos;
    logic [NUM_REQ-1:0]           req_ready;
    logic [NUM_REQ-1:0]           rsp_valid;
    logic [POS_BITS-1:0]          rsp_pos;
    logic                         rsp_hit;

    modport master (
        output req_valid, req_write, req_hash, req_pos,
        input  req_ready, rsp_valid, rsp_pos, rsp_hit
    );

    modport slave (
        input  req_valid, req_write, req_hash, req_pos,
        output req_ready, rsp_valid, rsp_pos, rsp_hit
    );
endinterface

// File: rtl/lzma2_rr_arbiter.sv
// rtl/lzma2_rr_arbiter.sv - round-robin grant, pointer advances past each winner
module lzma2_rr_arbiter #(
    parameter int N = 8,
    localparam int IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    output logic [N-1:0]  gnt,
    output logic [IW-1:0] gnt_idx,
    output logic          gnt_any
);
    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;

    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        gnt_any = 1'b0;
        cand    = '0;
        for (int off = 0; off < N; off++) begin
            cand = IW'((int'(ptr) + off) % N);
            if (!gnt_any && req[cand]) begin
                gnt_any = 1'b1;
                gnt_idx = cand;
            end
        end
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (gnt_any) begin
            ptr <= (gnt_idx == IW'(N - 1)) ? '0 : gnt_idx + 1'b1;
        end
    end
endmodule

// File: rtl/lzma2_hash_bank_arbiter.sv
// rtl/lzma2_hash_bank_arbiter.sv - shares one hash-head SRAM among parallel hash units
// Optional grant/stall counters: LZMA2_HASH_ARB_STATS_EN
module lzma2_hash_bank_arbiter
    import lzma2_compression_pkg::*;
#(
    parameter int NUM_REQ     = lzma2_compression_pkg::PARALLEL_HASH_UNITS,
    parameter int HASH_BITS   = lzma2_compression_pkg::HASH_BITS,
    parameter int POS_BITS    = 15,
    parameter int RAM_LATENCY = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    lzma2_hash_bank_arbiter_if.slave hb,
    input  logic                  clear_start,
    output logic                  clear_busy,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [HASH_BITS-1:0]  ram_addr,
    output logic [POS_BITS:0]     ram_wdata,
    input  logic [POS_BITS:0]     ram_rdata,
    output logic [31:0]           stat_grants,
    output logic [31:0]           stat_stalls
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    arb_state_t               state, state_d;
    logic [HASH_BITS-1:0]     clear_addr;
    logic [NUM_REQ-1:0]       arb_req, gnt;
    logic [IW-1:0]            gnt_idx;
    logic                     gnt_any;
    logic                     lookup_grant;
    logic [RAM_LATENCY-1:0]   tag_vld;
    logic [IW-1:0]            tag_idx [RAM_LATENCY];

    assign arb_req      = (state == RUN) ? hb.req_valid : '0;
    assign lookup_grant = gnt_any & ~hb.req_write[gnt_idx];
    assign hb.req_ready = gnt;

    lzma2_rr_arbiter #(.N(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (arb_req),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= CLEAR;
            clear_addr <= '0;
        end else begin
            state      <= state_d;
            clear_addr <= (state == CLEAR && !clear_start) ? clear_addr + 1'b1 : '0;
        end
    end

    // The clear drive is gated by rst_n so the SRAM sees no enable while held in reset.
    always_comb begin
        state_d    = state;
        clear_busy = (state != RUN);
        ram_en     = 1'b0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        ram_wdata  = '0;
        if (state == CLEAR && rst_n) begin
            ram_en   = 1'b1;
            ram_we   = 1'b1;
            ram_addr = clear_addr;
        end else if (gnt_any) begin
            ram_en   = 1'b1;
            ram_we   = hb.req_write[gnt_idx];
            ram_addr = hb.req_hash[gnt_idx*HASH_BITS +: HASH_BITS];
            if (hb.req_write[gnt_idx])
                ram_wdata = {1'b1, hb.req_pos[gnt_idx*POS_BITS +: POS_BITS]};
        end
        case (state)
            CLEAR:   if (!clear_start && (&clear_addr)) state_d = RUN;
            RUN:     if (clear_start) state_d = DRAIN;
            DRAIN:   if (tag_vld == '0) state_d = CLEAR;
            default: state_d = CLEAR;
        endcase
    end

    // Tag pipe tracks which unit owns the read data arriving RAM_LATENCY cycles later.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tag_vld <= '0;
            for (int k = 0; k < RAM_LATENCY; k++) tag_idx[k] <= '0;
        end else begin
            tag_vld[0] <= lookup_grant;
            tag_idx[0] <= gnt_idx;
            for (int k = 1; k < RAM_LATENCY; k++) begin
                tag_vld[k] <= tag_vld[k-1];
                tag_idx[k] <= tag_idx[k-1];
            end
        end
    end

    assign hb.rsp_valid = tag_vld[RAM_LATENCY-1] ? (NUM_REQ'(1) << tag_idx[RAM_LATENCY-1]) : '0;
    assign hb.rsp_pos   = tag_vld[RAM_LATENCY-1] ? ram_rdata[POS_BITS-1:0] : '0;
    assign hb.rsp_hit   = tag_vld[RAM_LATENCY-1] & ram_rdata[POS_BITS];

`ifdef LZMA2_HASH_ARB_STATS_EN
    logic [31:0] grants_q, stalls_q;
    logic        multi_req;

    assign multi_req = ($countones(hb.req_valid) > 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else if (state_d == CLEAR && state != CLEAR) begin
            grants_q <= '0;
            stalls_q <= '0;
        end else if (state == RUN) begin
            if (gnt_any && !(&grants_q)) grants_q <= grants_q + 1'b1;
            if (multi_req && !(&stalls_q)) stalls_q <= stalls_q + 1'b1;
        end
    end

    assign stat_grants = grants_q;
    assign stat_stalls = stalls_q;
`else
    assign stat_grants = '0;
    assign stat_stalls = '0;
`endif
endmodule

// File: tb/tb_lzma2_hash_bank_arbiter.sv
// tb/tb_lzma2_hash_bank_arbiter.sv - scoreboard bench with table and arbitration reference model
module tb_lzma2_hash_bank_arbiter;
    localparam int N     = 8;
    localparam int HB    = 15;
    localparam int PB    = 15;
    localparam int LAT   = 2;
    localparam int DEPTH = 1 << HB;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clear_start = 1'b0;
    logic clear_busy, ram_en, ram_we;
    logic [HB-1:0] ram_addr;
    logic [PB:0]   ram_wdata, ram_rdata, rd_s1;
    logic [31:0]   stat_grants, stat_stalls;

    always #5 clk = ~clk;

    lzma2_hash_bank_arbiter_if #(.NUM_REQ(N), .HASH_BITS(HB), .POS_BITS(PB)) hbif ();

    lzma2_hash_bank_arbiter #(.NUM_REQ(N), .HASH_BITS(HB), .POS_BITS(PB), .RAM_LATENCY(LAT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .hb          (hbif.slave),
        .clear_start (clear_start),
        .clear_busy  (clear_busy),
        .ram_en      (ram_en),
        .ram_we      (ram_we),
        .ram_addr    (ram_addr),
        .ram_wdata   (ram_wdata),
        .ram_rdata   (ram_rdata),
        .stat_grants (stat_grants),
        .stat_stalls (stat_stalls)
    );

    // SRAM with two-cycle read latency
    logic [PB:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) mem[ram_addr] <= ram_wdata;
            else        rd_s1 <= mem[ram_addr];
        end
        ram_rdata <= rd_s1;
    end

    // reference model
    logic [PB:0] ref_mem [DEPTH];
    int last_g = N - 1;
    int m_grants = 0;
    int m_stalls = 0;
    int cyc = 0;
    int n_chk = 0;
    int n_pass = 0;

    typedef struct {
        int          unit;
        logic [PB:0] data;
        int          due;
    } exp_t;
    exp_t sbq[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    endtask

    // monitor
    always @(negedge clk) begin : monitor
        exp_t e;
        #2;
        if (sbq.size() != 0 && sbq[0].due < cyc) begin
            e = sbq.pop_front();
            chk("rsp_missing", 32'(cyc), 32'(e.due));
        end
        if (hbif.rsp_valid != '0) begin
            if (sbq.size() == 0) begin
                chk("unexpected_rsp", 32'(hbif.rsp_valid), 32'd0);
            end else begin
                e = sbq.pop_front();
                chk("rsp_valid", 32'(hbif.rsp_valid), 32'(1) << e.unit);
                chk("rsp_pos", 32'(hbif.rsp_pos), 32'(e.data[PB-1:0]));
                chk("rsp_hit", 32'(hbif.rsp_hit), 32'(e.data[PB]));
                chk("rsp_latency", 32'(cyc), 32'(e.due));
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic [N-1:0] w,
                        input logic [N*HB-1:0] h, input logic [N*PB-1:0] p, output int g);
        logic [N-1:0] expg;
        logic [HB-1:0] a;
        hbif.req_valid = v;
        hbif.req_write = w;
        hbif.req_hash  = h;
        hbif.req_pos   = p;
        #1;
        g = -1;
        expg = '0;
        for (int k = 1; k <= N; k++) begin
            int u;
            u = (last_g + k) % N;
            if (g < 0 && v[u]) g = u;
        end
        if ($countones(v) > 1) m_stalls++;
        if (g >= 0) begin
            expg[g] = 1'b1;
            last_g = g;
            m_grants++;
            a = h[g*HB +: HB];
            if (w[g]) ref_mem[a] = {1'b1, p[g*PB +: PB]};
            else      sbq.push_back('{g, ref_mem[a], cyc + LAT});
        end
        chk("grant", 32'(hbif.req_ready), 32'(expg));
        @(negedge clk);
    endtask

    task automatic one(input int u, input bit wr, input logic [HB-1:0] h, input logic [PB-1:0] p);
        logic [N-1:0] v, w;
        logic [N*HB-1:0] hv;
        logic [N*PB-1:0] pv;
        int g;
        v = '0; w = '0; hv = '0; pv = '0;
        v[u] = 1'b1;
        w[u] = wr;
        hv[u*HB +: HB] = h;
        pv[u*PB +: PB] = p;
        step(v, w, hv, pv, g);
    endtask

    task automatic idle(input int n);
        hbif.req_valid = '0;
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic chk_stats();
`ifdef LZMA2_HASH_ARB_STATS_EN
        chk("stat_grants", stat_grants, 32'(m_grants));
        chk("stat_stalls", stat_stalls, 32'(m_stalls));
`else
        chk("stat_grants_off", stat_grants, 32'd0);
        chk("stat_stalls_off", stat_stalls, 32'd0);
`endif
    endtask

    initial begin
        int g, bad, busy, nwe;
        logic [N-1:0] pend;
        logic [N*HB-1:0] hv;
        logic [N*PB-1:0] pv;

        hbif.req_valid = '0;
        hbif.req_write = '0;
        hbif.req_hash  = '0;
        hbif.req_pos   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            mem[i] = (PB+1)'($urandom);
            ref_mem[i] = '0;
        end

        // reset values
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(hbif.req_ready), 0);
        chk("rst_rsp_valid", 32'(hbif.rsp_valid), 0);
        chk("rst_rsp_pos", 32'(hbif.rsp_pos), 0);
        chk("rst_rsp_hit", 32'(hbif.rsp_hit), 0);
        chk("rst_clear_busy", 32'(clear_busy), 1);
        chk("rst_ram_en", 32'(ram_en), 0);
        chk("rst_ram_we", 32'(ram_we), 0);
        chk("rst_ram_addr", 32'(ram_addr), 0);
        chk("rst_ram_wdata", 32'(ram_wdata), 0);
        chk("rst_stat_grants", stat_grants, 0);
        chk("rst_stat_stalls", stat_stalls, 0);
        @(negedge clk);

        // initial clear sweep
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            if (!(ram_en && ram_we && ram_addr == HB'(i) && ram_wdata == '0 &&
                  clear_busy && hbif.req_ready == '0)) bad++;
            @(negedge clk);
        end
        chk("init_clear_bad_cycles", 32'(bad), 0);
        #1;
        chk("init_clear_done", 32'(clear_busy), 0);
        chk("run_idle_ram_en", 32'(ram_en), 0);
        @(negedge clk);

        // insert then lookup of the same address on the next cycle
        one(3, 1'b1, 15'h1234, 15'h0456);
        one(5, 1'b0, 15'h1234, 15'h0000);
        idle(4);

        // all units hold lookups with rr_ptr at 0
        one(7, 1'b0, 15'h0100, 15'h0);
        idle(3);
        chk_stats();
        pend = '1;
        for (int i = 0; i < N; i++) hv[i*HB +: HB] = 15'h1230 + HB'(i);
        for (int c = 0; c < N; c++) begin
            step(pend, '0, hv, '0, g);
            chk("held_grant_order", 32'(g), 32'(c));
            if (g >= 0) pend[g] = 1'b0;
        end
        hbif.req_valid = '0;
        #1;
        chk_stats();
        @(negedge clk);
        step('1, '0, hv, '0, g);
        chk("wrap_grant", 32'(g), 0);
        idle(4);

        // unwritten entry
        one(6, 1'b0, 15'h7FFF, 15'h0);
        idle(4);

        // randomized traffic over a small address window
        for (int c = 0; c < 300; c++) begin
            for (int i = 0; i < N; i++) begin
                hv[i*HB +: HB] = 15'h1230 + HB'($urandom_range(0, 15));
                pv[i*PB +: PB] = PB'($urandom);
            end
            step(N'($urandom), N'($urandom), hv, pv, g);
        end
        idle(4);
        chk_stats();

        // clear on command with a lookup in flight
        one(2, 1'b0, 15'h1234, 15'h0);
        clear_start = 1'b1;
        step('0, '0, '0, '0, g);
        clear_start = 1'b0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
        m_grants = 0;
        m_stalls = 0;
        bad = 0; busy = 0; nwe = 0;
        for (int i = 0; i < 40000; i++) begin
            hbif.req_valid = N'($urandom);
            #1;
            if (!clear_busy) begin
                hbif.req_valid = '0;
                break;
            end
            busy++;
            if (hbif.req_ready != '0) bad++;
            if (ram_we) begin
                if (ram_addr != HB'(nwe) || ram_wdata != '0) bad++;
                nwe++;
            end
            @(negedge clk);
        end
        @(negedge clk);
        chk("cmd_clear_bad_cycles", 32'(bad), 0);
        chk("cmd_clear_busy_cycles", 32'(busy), 32'(DEPTH + 2));
        chk("cmd_clear_writes", 32'(nwe), 32'(DEPTH));
        chk_stats();
        one(4, 1'b0, 15'h1234, 15'h0);
        idle(4);
        chk_stats();
        chk("scoreboard_drained", 32'(sbq.size()), 0);

        // reset one cycle after a lookup grant
        one(1, 1'b0, 15'h1234, 15'h0);
        rst_n = 1'b0;
        sbq.delete();
        last_g = N - 1;
        m_grants = 0;
        m_stalls = 0;
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (!(ram_we && ram_addr == HB'(i) && clear_busy)) bad++;
            @(negedge clk);
        end
        chk("reset_restart_clear", 32'(bad), 0);
        chk_stats();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/lzma2_hash_bank_arbiter.md
Name: lzma2_hash_bank_arbiter

Overview:
- Shares one single-port hash-head SRAM among NUM_REQ parallel hash units in the match finder.
- Each hash unit issues lookups (read head position for a 3-byte hash) or inserts (write the current position).
- A round-robin arbiter grants one operation per cycle and returns lookup data to the originating unit with fixed latency.
- A sequencer clears the whole table after reset and on command, before matching starts on a new 32KB block.

Parameters:
NUM_REQ, 8, number of requesting hash units (matches PARALLEL_HASH_UNITS)
HASH_BITS, 15, table address width; table depth 2^HASH_BITS
POS_BITS, 15, stored position width (32KB window)
RAM_LATENCY, 2, SRAM read latency in cycles (>=1)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  NUM_REQ  per-unit request
req_write  in  NUM_REQ  1=insert, 0=lookup
req_hash  in  NUM_REQ*HASH_BITS  per-unit table address, unit i at [i*HASH_BITS +: HASH_BITS]
req_pos  in  NUM_REQ*POS_BITS  insert data, same packing
req_ready  out  NUM_REQ  one-hot grant; transfer when req_valid[i]&req_ready[i]
rsp_valid  out  NUM_REQ  one-hot lookup-response strobe
rsp_pos  out  POS_BITS  lookup result, shared bus
rsp_hit  out  1  entry valid bit of result
clear_start  in  1  pulse: re-clear table
clear_busy  out  1  high during DRAIN/CLEAR
ram_en  out  1  SRAM enable
ram_we  out  1  SRAM write enable
ram_addr  out  HASH_BITS  SRAM address
ram_wdata  out  POS_BITS+1  {valid,pos}
ram_rdata  in  POS_BITS+1  {valid,pos}, RAM_LATENCY after read
stat_grants  out  32  granted-operation count (optional feature)
stat_stalls  out  32  contention count (optional feature)

Behaviour:
- Reset: state=CLEAR, clear_addr=0, rr_ptr=0, tag pipe empty. Outputs: req_ready=0, rsp_valid=0, rsp_pos=0, rsp_hit=0, clear_busy=1, ram_en=0, ram_we=0, ram_addr=0, ram_wdata=0, stats=0.
- FSM states:
  - CLEAR: each cycle ram_en=ram_we=1, ram_addr=clear_addr, ram_wdata=0; clear_addr++. After address 2^HASH_BITS-1 -> RUN. Clear takes exactly 2^HASH_BITS cycles. req_ready=0 throughout.
  - RUN: clear_busy=0. Arbitration is combinational: the grant goes to the first i with req_valid[i], searching from rr_ptr upward modulo NUM_REQ. req_ready is that one-hot vector (all zero if none valid). On a grant to unit g, rr_ptr <= (g+1) mod NUM_REQ. Fairness: a held request is granted within NUM_REQ-1 other grants.
  - Granted op drives ram_en=1, ram_we=req_write[g], ram_addr=req_hash[g] in the same cycle. An insert writes ram_wdata={1'b1, req_pos[g]}; a lookup writes ram_wdata=0.
  - Lookup: a tag (unit index, valid) enters a RAM_LATENCY-deep shift pipe. When the tag exits, rsp_valid[tag]=1 for one cycle, with rsp_pos=ram_rdata[POS_BITS-1:0] and rsp_hit=ram_rdata[POS_BITS]. Inserts produce no response.
  - Ordering: operations take effect in grant order. A lookup granted the cycle after an insert to the same address returns the new data. The SRAM is write-visible next cycle.
  - clear_start in RUN -> DRAIN. No new grants in DRAIN. Once the tag pipe is empty (in-flight responses delivered), go to CLEAR with clear_addr=0.
  - clear_start in CLEAR or DRAIN: clear_addr restarts at 0; the state is otherwise unchanged.
- Reset mid-operation: in-flight responses are discarded; rsp_valid is never asserted for pre-reset requests.

Optional Feature:
LZMA2_HASH_ARB_STATS_EN
- Defined:
  - stat_grants increments on every RUN grant.
  - stat_stalls increments each RUN cycle where popcount(req_valid) > 1.
  - Both counters saturate at 32'hFFFFFFFF and reset to 0 on rst_n and on entering CLEAR.
- Undefined: both ports are tied to 0 and no counter logic is built.

Decomposition:
- Shared package, lzma2_compression_pkg: HASH_BITS, PARALLEL_HASH_UNITS, and a hash_req_t typedef {write, hash, pos}.
- New items in that package: the arb_state_t enum {CLEAR, RUN, DRAIN} and hash_head_t {valid, pos[14:0]}.
- One sub-module: lzma2_rr_arbiter (parametric round-robin grant plus pointer update), reused elsewhere in the compressor.

Test Plan:
- Reset release, no requests: ram_we=1 with addresses 0..32767 for 32768 consecutive cycles, ram_wdata=0, clear_busy=1 throughout -> RUN, clear_busy=0.
- Unit 3 inserts hash 0x1234 pos 0x0456. Next cycle unit 5 looks up 0x1234 -> rsp_valid=8'b0010_0000 two cycles after its grant, rsp_pos=0x0456, rsp_hit=1.
- All 8 units hold lookups with rr_ptr=0 -> grants 0,1,...,7 on consecutive cycles, then 0 again. With stats enabled, stat_stalls=7 after the first 8 cycles.
- Lookup of an unwritten hash 0x7FFF -> rsp_hit=0, rsp_pos=0.
- Lookup granted, then clear_start the next cycle -> no grants until the response is delivered, then a full 32768-cycle clear. A later lookup of a previously inserted hash returns rsp_hit=0.
- rst_n low one cycle after a lookup grant -> no rsp_valid afterwards. FSM restarts CLEAR at address 0.
